spike_out_queue: RTL
====================

# spike_out_queue

Output stage placed directly downstream of the neuron tile. It captures the configured AER spike packet each time the neuron datapath fires, tags it with the current time-step index, and buffers it in a small FIFO. It then hands packets to the router over a valid/ready handshake. Overflow drops are counted, and a busy flag tells the tile controller when all spikes from a step have left.

## Interface
Parameters:
- AER_BIT_WIDTH, 32, width of the spike packet from config memory
- TS_BIT_WIDTH, 8, width of the time-step tag
- FIFO_DEPTH, 4, number of entries; power of two, at least 2
- FIFO_PTR_WIDTH, 2, log2(FIFO_DEPTH)
- DROP_CNT_BIT_WIDTH, 8, width of the saturating drop counter

Ports (one clock; reset is synchronous and active-high):
- clk_i, in, 1, tile clock
- rst_i, in, 1, synchronous active-high reset
- start_i, in, 1, time-step start pulse, the same pulse the neuron controller receives
- outSpike_i, in, 1, fire pulse from the neuron datapath
- SpikeAER_i, in, AER_BIT_WIDTH, spike packet from config memory, valid while outSpike_i=1
- pkt_o, out, AER_BIT_WIDTH, head packet to the router
- pkt_ts_o, out, TS_BIT_WIDTH, time-step tag of the head packet
- pkt_valid_o, out, 1, head entry is valid
- pkt_ready_i, in, 1, router accepts the packet
- busy_o, out, 1, FIFO is not empty
- overflow_o, out, 1, sticky flag: at least one spike was dropped
- drop_cnt_o, out, DROP_CNT_BIT_WIDTH, saturating count of dropped spikes

## Operation
Time-step counter ts:
- Resets to 0.
- Increments by 1 mod 2^TS_BIT_WIDTH on every cycle with start_i=1.
- A spike captured in the same cycle as start_i is tagged with the old ts value, because the fire belongs to the finishing step.

Capture (push): on a cycle with outSpike_i=1, write {SpikeAER_i, ts} at the write pointer, provided the FIFO is not full or a pop happens in the same cycle.

Pop: occurs when pkt_valid_o=1 and pkt_ready_i=1. The read pointer advances.

Simultaneous push and pop:
- When full: both happen and the count is unchanged. There is no drop.
- When empty: no pop can occur, because valid is low. The push completes and valid rises the next cycle.

Drop: a push while full with no pop.
- The entry is discarded.
- overflow_o is set to 1 and stays at 1 until reset.
- drop_cnt_o increments and saturates at all-ones.

Pointers wrap modulo FIFO_DEPTH. The full/empty decision uses a count register of width FIFO_PTR_WIDTH+1.

Handshake:
- pkt_o, pkt_ts_o and pkt_valid_o reflect the head entry only.
- Once valid is high it stays high, with data unchanged, until accepted.
- pkt_ready_i has no effect while valid is low.

busy_o equals (count != 0).

Reset mid-operation: all buffered entries are discarded, and pointers, count, ts, overflow_o and drop_cnt_o are cleared.

## Timing
Reset values: pkt_o=0, pkt_ts_o=0, pkt_valid_o=0, busy_o=0, overflow_o=0, drop_cnt_o=0.

Latencies:
- Push to pkt_valid_o: 1 cycle. There is no combinational bypass.
- Pop to next head visible: 1 cycle. Back-to-back pops at 1 packet per cycle are supported.
- Drop to overflow_o and drop_cnt_o update: 1 cycle.

Paths:
- No combinational path from pkt_ready_i to pkt_valid_o or pkt_o.
- All outputs are registered or decoded from registered state.

## Structure
Package spike_out_pkg holds:
- default widths
- the entry type {aer, ts}
- the drop-counter saturation constant

Sub-module sync_fifo, parameterised on data width and depth, implements storage, pointers, count, full and empty. spike_out_queue wraps it and adds the ts counter, drop logic and handshake mapping.

## Test plan
- Reset, then a single spike with SpikeAER_i=32'h0001_0003 at ts=0 and pkt_ready_i=1. pkt_valid_o rises 1 cycle later with pkt_o=32'h0001_0003 and pkt_ts_o=0. It drops the next cycle and busy_o returns to 0.
- Three start_i pulses, then a spike. pkt_ts_o=3. A spike in the same cycle as a 4th start_i also gets pkt_ts_o=3, and a following spike gets 4.
- pkt_ready_i=0 with 6 spikes pushed (values 1..6). 4 are stored, overflow_o=1 and drop_cnt_o=2. After ready rises, packets 1,2,3,4 come out in order on 4 consecutive cycles.
- FIFO full, then push and pop in the same cycle. No drop occurs, drop_cnt_o is unchanged, and the new entry appears last.
- Stall: pkt_ready_i toggles 0/1 every cycle. pkt_o stays stable while valid=1 and ready=0, and there is no loss or duplication over 10 packets.
- Force 300 drops. drop_cnt_o saturates at 255. Assert rst_i for 1 cycle mid-stream: all outputs return to 0 and the next spike is tagged ts=0.

Source files
------------

// File: rtl/spike_out_pkg.sv
// Shared widths, the buffered spike entry layout and the drop-counter
// saturation value for the spike output queue.
package spike_out_pkg;

   localparam int AER_W_DEF      = 32;
   localparam int TS_W_DEF       = 8;
   localparam int FIFO_DEPTH_DEF = 4;
   localparam int FIFO_PTR_W_DEF = 2;
   localparam int DROP_CNT_W_DEF = 8;

   // One buffered spike: the AER packet plus the time step it fired in.
   typedef struct packed {
      logic [AER_W_DEF-1:0] aer;
      logic [TS_W_DEF-1:0]  ts;
   } spikeEntry_t;

   localparam logic [DROP_CNT_W_DEF-1:0] DROP_CNT_SAT = '1;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a count register. The head entry is always
// visible on popData, so a reader sees new data one cycle after a push or pop.
module sync_fifo #(
   parameter int DATA_WIDTH = 40,
   parameter int DEPTH      = 4,
   parameter int PTR_WIDTH  = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  pushReq,
   input  logic                  popReq,
   input  logic [DATA_WIDTH-1:0] pushData,
   output logic [DATA_WIDTH-1:0] popData,
   output logic                  full,
   output logic                  empty,
   output logic [PTR_WIDTH:0]    count
);

   localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_WIDTH-1:0]  wrPtr;
   logic [PTR_WIDTH-1:0]  rdPtr;
   logic                  pushAccept;
   logic                  popAccept;

   assign full       = (count == FULL_COUNT);
   assign empty      = (count == '0);
   assign popAccept  = popReq && !empty;
   assign pushAccept = pushReq && (!full || popAccept);
   assign popData    = mem[rdPtr];

   // Storage, pointers and occupancy; reset also wipes storage so the head reads zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (pushAccept) begin
            mem[wrPtr] <= pushData;
            wrPtr      <= wrPtr + 1'b1;
         end
         if (popAccept) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({pushAccept, popAccept})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spike_out_queue.sv
// Output stage behind the neuron tile: tags each fired spike with the current
// time step, buffers it, and hands it to the router over valid/ready.
module spike_out_queue
   import spike_out_pkg::*;
#(
   parameter int AER_BIT_WIDTH      = AER_W_DEF,
   parameter int TS_BIT_WIDTH       = TS_W_DEF,
   parameter int FIFO_DEPTH         = FIFO_DEPTH_DEF,
   parameter int FIFO_PTR_WIDTH     = FIFO_PTR_W_DEF,
   parameter int DROP_CNT_BIT_WIDTH = DROP_CNT_W_DEF
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          start_i,
   input  logic                          outSpike_i,
   input  logic [AER_BIT_WIDTH-1:0]      SpikeAER_i,
   output logic [AER_BIT_WIDTH-1:0]      pkt_o,
   output logic [TS_BIT_WIDTH-1:0]       pkt_ts_o,
   output logic                          pkt_valid_o,
   input  logic                          pkt_ready_i,
   output logic                          busy_o,
   output logic                          overflow_o,
   output logic [DROP_CNT_BIT_WIDTH-1:0] drop_cnt_o
);

   localparam int ENTRY_W = AER_BIT_WIDTH + TS_BIT_WIDTH;
   localparam logic [DROP_CNT_BIT_WIDTH-1:0] DROP_MAX = '1;

   logic [TS_BIT_WIDTH-1:0] ts;
   logic [ENTRY_W-1:0]      pushData;
   logic [ENTRY_W-1:0]      headData;
   logic                    popReq;
   logic                    fifoFull;
   logic                    fifoEmpty;
   logic [FIFO_PTR_WIDTH:0] fifoCount;
   logic                    dropEvent;

   // The old ts value is captured here, so a fire coinciding with start belongs to the finishing step.
   assign pushData  = {SpikeAER_i, ts};
   assign popReq    = pkt_valid_o && pkt_ready_i;
   assign dropEvent = outSpike_i && fifoFull && !popReq;

   sync_fifo #(
      .DATA_WIDTH(ENTRY_W),
      .DEPTH     (FIFO_DEPTH),
      .PTR_WIDTH (FIFO_PTR_WIDTH)
   ) fifo (
      .clock   (clk_i),
      .reset   (rst_i),
      .pushReq (outSpike_i),
      .popReq  (popReq),
      .pushData(pushData),
      .popData (headData),
      .full    (fifoFull),
      .empty   (fifoEmpty),
      .count   (fifoCount)
   );

   // Time-step index advances once per start pulse and wraps naturally.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ts <= '0;
      end else if (start_i) begin
         ts <= ts + 1'b1;
      end
   end

   // Sticky overflow flag and saturating count of spikes lost to a full queue.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         overflow_o <= 1'b0;
         drop_cnt_o <= '0;
      end else if (dropEvent) begin
         overflow_o <= 1'b1;
         if (drop_cnt_o != DROP_MAX) begin
            drop_cnt_o <= drop_cnt_o + 1'b1;
         end
      end
   end

   assign pkt_valid_o = !fifoEmpty;
   assign busy_o      = (fifoCount != '0);
   assign pkt_o       = headData[ENTRY_W-1:TS_BIT_WIDTH];
   assign pkt_ts_o    = headData[TS_BIT_WIDTH-1:0];

endmodule
